// File: rtl/sync_pulse_decoder.sv
// Recovers column/row position from h/v sync pulses and tracks lock to the stream.
// Define SYNC_PULSE_DECODER_ERR_CNT_EN to build the saturating error tally on err_count.
module sync_pulse_decoder #(
  parameter int DISP_COLS  = 640,
  parameter int DISP_ROWS  = 480,
  parameter int TOTAL_COLS = 800,
  parameter int TOTAL_ROWS = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [11:0] col_count,
  output logic [11:0] row_count,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic        active,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_error,
  output logic [15:0] err_count
);

  localparam logic [11:0] COL_LAST      = 12'(TOTAL_COLS - 1);
  localparam logic [11:0] ROW_LAST      = 12'(TOTAL_ROWS - 1);
  localparam logic [11:0] COL_DISP_LAST = 12'(DISP_COLS - 1);
  localparam logic [11:0] ROW_DISP_LAST = 12'(DISP_ROWS - 1);
  localparam logic [11:0] COL_DISP      = 12'(DISP_COLS);
  localparam logic [11:0] ROW_DISP      = 12'(DISP_ROWS);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        h_s1_q, h_s2_q, v_s1_q, v_s2_q;
  logic        h_rise, h_fall, v_rise, v_fall;
  logic [11:0] col_q, col_d, row_q, row_d;
  logic        col_timeout, row_timeout, violation, err_d;
  logic        fs_q;
  logic [11:0] col_out_q, row_out_q;
  logic        h_out_q, v_out_q, active_q, fs_out_q, locked_q, err_q;

  always_comb begin
    h_rise = h_s1_q & ~h_s2_q;
    h_fall = ~h_s1_q & h_s2_q;
    v_rise = v_s1_q & ~v_s2_q;
    v_fall = ~v_s1_q & v_s2_q;

    col_d       = col_q;
    col_timeout = 1'b0;
    if (h_rise) begin
      col_d = '0;
    end else if (col_q == COL_LAST) begin
      col_timeout = 1'b1;
    end else begin
      col_d = col_q + 12'd1;
    end

    // Rows advance only on line starts; a missing frame start pins the row at the last line.
    row_d       = row_q;
    row_timeout = 1'b0;
    if (h_rise) begin
      if (v_rise) begin
        row_d = '0;
      end else if (row_q == ROW_LAST) begin
        row_timeout = 1'b1;
      end else begin
        row_d = row_q + 12'd1;
      end
    end

    violation = (h_rise && (col_q != COL_LAST))
             || (h_fall && (col_q != COL_DISP_LAST))
             || (v_rise && (row_q != ROW_LAST))
             || (v_fall && !(h_rise && (row_q == ROW_DISP_LAST)))
             || col_timeout || row_timeout;
    err_d = violation && (state_q != SEARCH);

    state_d = state_q;
    case (state_q)
      SEARCH: if (v_rise) state_d = TRACK;
      TRACK: begin
        if (err_d) state_d = SEARCH;
        else if (v_rise) state_d = LOCKED;
      end
      LOCKED: if (err_d) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      h_s1_q    <= 1'b0;
      h_s2_q    <= 1'b0;
      v_s1_q    <= 1'b0;
      v_s2_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
      col_out_q <= '0;
      row_out_q <= '0;
      h_out_q   <= 1'b0;
      v_out_q   <= 1'b0;
      active_q  <= 1'b0;
      fs_out_q  <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_s1_q    <= h_sync;
      h_s2_q    <= h_s1_q;
      v_s1_q    <= v_sync;
      v_s2_q    <= v_s1_q;
      col_q     <= col_d;
      row_q     <= row_d;
      fs_q      <= h_rise & v_rise;
      err_q     <= err_d;
      // Output stage: one more register so counters line up with the twice-delayed syncs.
      col_out_q <= col_q;
      row_out_q <= row_q;
      h_out_q   <= h_s2_q;
      v_out_q   <= v_s2_q;
      active_q  <= (col_q < COL_DISP) && (row_q < ROW_DISP);
      fs_out_q  <= fs_q;
      locked_q  <= (state_q == LOCKED);
    end
  end

  assign col_count   = col_out_q;
  assign row_count   = row_out_q;
  assign h_sync_out  = h_out_q;
  assign v_sync_out  = v_out_q;
  assign active      = active_q;
  assign frame_start = fs_out_q;
  assign locked      = locked_q;
  assign sync_error  = err_q;

`ifdef SYNC_PULSE_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/sync_pulse_decoder.md
SYNC_PULSE_DECODER -- requirements
Module: sync_pulse_decoder

Interface
REQ-001 Parameters SHALL be: DISP_COLS, default 640, active columns per line; DISP_ROWS, default 480, active rows per frame; TOTAL_COLS, default 800, columns per line including blanking; TOTAL_ROWS, default 525, rows per frame including blanking.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 h_sync  input  1  high for the first DISP_COLS clocks of each TOTAL_COLS-clock line, low otherwise.
REQ-005 v_sync  input  1  high for the first DISP_ROWS whole lines of each TOTAL_ROWS-line frame; rises in the same clock as the h_sync rise of row 0.
REQ-006 col_count  output  12  recovered column index, 0..TOTAL_COLS-1.
REQ-007 row_count  output  12  recovered row index, 0..TOTAL_ROWS-1.
REQ-008 h_sync_out, v_sync_out  output  1 each  inputs delayed 2 clocks, aligned with col_count/row_count.
REQ-009 active  output  1  high when col_count < DISP_COLS and row_count < DISP_ROWS.
REQ-010 frame_start  output  1  one-clock pulse aligned with col_count=0, row_count=0.
REQ-011 locked  output  1  high only in state LOCKED.
REQ-012 sync_error  output  1  one-clock pulse on any timing violation.
REQ-013 err_count  output  16  error tally (see Configuration).

Function
REQ-014 Both inputs SHALL be registered once (stage s1), then again (stage s2); h_rise = h_s1 & ~h_s2, h_fall = ~h_s1 & h_s2, v_rise = v_s1 & ~v_s2.
REQ-015 Total latency: an input sample taken at edge t SHALL appear on h_sync_out/v_sync_out at edge t+2, with col_count/row_count describing that sample.
REQ-016 col_count SHALL load 0 on h_rise, else increment; at TOTAL_COLS-1 without h_rise it SHALL hold and flag a timeout error (REQ-021).
REQ-017 row_count SHALL load 0 on h_rise coincident with v_rise, increment on any other h_rise, and hold at TOTAL_ROWS-1 (error per REQ-021).
REQ-018 All outputs other than sync_error, frame_start and err_count SHALL be registered and mutually aligned.
REQ-019 FSM states SEARCH, TRACK, LOCKED; reset state SEARCH.
REQ-020 Transitions: SEARCH->TRACK on v_rise; TRACK->LOCKED on next v_rise with no error since entry; TRACK->SEARCH on error; LOCKED->SEARCH on error; error and v_rise in the same clock -> SEARCH.
REQ-021 Error conditions, checked in TRACK and LOCKED only: h_rise with col_count != TOTAL_COLS-1; h_fall with col_count != DISP_COLS-1; v_rise with row_count != TOTAL_ROWS-1; v_s1 falling when row_count != DISP_ROWS-1 at h_rise; col_count or row_count timeout.
REQ-022 Multiple simultaneous errors SHALL produce a single sync_error pulse and one err_count increment.
REQ-023 In SEARCH, counters SHALL still track edges, but sync_error SHALL stay 0.

Reset
REQ-024 While rst is high at a clock edge: state SEARCH; s1/s2 stages, col_count, row_count, h_sync_out, v_sync_out, active, frame_start, locked, sync_error all 0; err_count 0.
REQ-025 Reset mid-frame SHALL discard lock; relock SHALL require two further v_rise events.

Configuration
REQ-026 With SYNC_PULSE_DECODER_ERR_CNT_EN defined, err_count SHALL increment by 1 per sync_error pulse, saturate at 16'hFFFF, and clear only on rst.
REQ-027 Without SYNC_PULSE_DECODER_ERR_CNT_EN, err_count SHALL be constant 0 and no counter logic synthesised; all other behaviour is identical.

Verification (DISP_COLS=8, DISP_ROWS=4, TOTAL_COLS=10, TOTAL_ROWS=6)
REQ-028 Reset, then clean stream from mid-frame -> locked rises 2 clocks after second frame's v_sync rise; col_count cycles 0..9, row_count 0..5; frame_start once per 60 clocks.
REQ-029 Clean locked stream -> active high exactly 32 clocks per frame, at col<8, row<4; h_sync_out equals h_sync delayed 2 clocks.
REQ-030 While locked, one line shortened to 9 clocks -> one sync_error pulse, locked falls next clock, relocks after two clean v_sync rises.
REQ-031 h_sync held low 15 clocks while locked -> col_count holds at 9, sync_error pulse, state SEARCH.
REQ-032 rst asserted at row 2 col 5 -> all outputs 0 next clock; locked stays low until second subsequent v_sync rise.
REQ-033 Macro defined, three injected errors -> err_count=3; macro undefined, same stimulus -> err_count=0, sync_error pulses unchanged.
